rd_first_edge_addr_gen: RTL
===========================

RD_FIRST_EDGE_ADDR_GEN -- requirements
Module: rd_first_edge_addr_gen

Interface
REQ-001 The block SHALL have parameters: V_ID_WIDTH, 32, vertex id width; V_VALUE_WIDTH, 32, vertex value width; FIRST_EDGE_BRAM_AWIDTH, 11, first-edge BRAM address width; CORE_NUM, 16, lane count; CORE_NUM_WIDTH, 4, log2(CORE_NUM); FIFO_AWIDTH, 4, log2 of per-lane FIFO depth; FULL_THRESHOLD, 12, occupancy that raises stage_full.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The ports SHALL be as follows:
- clk  in  1  clock.
- rst  in  CORE_NUM  per-lane synchronous active-low reset.
- front_push_flag  in  CORE_NUM  push/pull mode per lane.
- front_active_v_id  in  CORE_NUM*V_ID_WIDTH  active vertex id.
- front_active_v_value  in  CORE_NUM*V_VALUE_WIDTH  active vertex value.
- front_active_v_valid  in  CORE_NUM  vertex qualifier.
- front_iteration_end  in  CORE_NUM  iteration-end flag.
- front_iteration_end_valid  in  CORE_NUM  end qualifier.
- next_stage_full  in  CORE_NUM  downstream (first-edge BRAM read stage) backpressure.
- stage_full  out  CORE_NUM  backpressure to upstream.
- rd_edge_addr  out  CORE_NUM*FIRST_EDGE_BRAM_AWIDTH  first-edge BRAM address.
- push_flag  out  CORE_NUM  forwarded push flag.
- active_v_id  out  CORE_NUM*V_ID_WIDTH  forwarded id.
- active_v_value  out  CORE_NUM*V_VALUE_WIDTH  forwarded value.
- rd_edge_valid  out  CORE_NUM  address/vertex qualifier.
- iteration_end  out  CORE_NUM  forwarded end flag.
- iteration_end_valid  out  CORE_NUM  end qualifier.
- overflow_err  out  CORE_NUM  sticky write-while-full flag.

Function
REQ-004 Each lane SHALL operate independently: one FIFO (depth 2^FIFO_AWIDTH), one occupancy counter, one output FSM.
REQ-005 FIFO entry fields: push_flag, v_id, v_value, v_flag, end, end_flag; a write occurs when front_active_v_valid or front_iteration_end_valid is 1.
REQ-006 If both qualifiers are 1 in the same cycle, the block SHALL write one entry with v_flag=1 and end_flag=1.
REQ-007 A write while the FIFO is full SHALL be dropped and SHALL set overflow_err, which holds until reset.
REQ-008 stage_full SHALL be registered and SHALL be 1 in the cycle after occupancy reaches >= FULL_THRESHOLD.
REQ-009 Address: rd_edge_addr = (v_id >> CORE_NUM_WIDTH) truncated to the low FIRST_EDGE_BRAM_AWIDTH bits; end-only entries output address 0.
REQ-010 Output FSM states: EMIT, EMIT_END.
- In EMIT, a pop occurs when the FIFO is non-empty and next_stage_full=0.
- A v_flag=1 entry SHALL load the outputs with rd_edge_valid=1.
- An end-only entry SHALL load iteration_end and iteration_end_valid=1.
- A v_flag=1, end_flag=1 entry SHALL emit the vertex and go to EMIT_END without freeing the entry.
- EMIT_END SHALL emit the end token when next_stage_full=0, free the entry and return to EMIT.
REQ-011 rd_edge_valid and iteration_end_valid SHALL never both be 1 in a lane in the same cycle.
REQ-012 Outputs SHALL be registered; valids are 1-cycle pulses per emitted item; data fields hold their last values while valids are 0.
REQ-013 Latency with an empty FIFO and next_stage_full=0: input sampled at edge k, output valid after edge k+1.
REQ-014 A simultaneous write and pop SHALL leave occupancy unchanged; pop while full with a write frees a slot and accepts the write.
REQ-015 Pointers SHALL wrap modulo 2^FIFO_AWIDTH; occupancy is FIFO_AWIDTH+1 bits.
REQ-016 While next_stage_full=1 no pop SHALL occur; a pop SHALL be permitted in the first cycle next_stage_full returns to 0.
REQ-017 Order SHALL be preserved per lane: every vertex written before an end token is emitted before it.

Reset
REQ-018 With rst[i]=0 at a clock edge, lane i SHALL clear pointers, occupancy, overflow_err and all outputs to 0, set the FSM to EMIT, and discard FIFO contents, including mid-operation and in EMIT_END.
REQ-019 Reset of lane i SHALL NOT affect other lanes.

Verification
REQ-020 Reset 10 cycles, release, inputs idle -> all outputs 0 on every lane.
REQ-021 Lane i, one cycle front_active_v_id=0x35+i, value=1, valid=1, next_stage_full=0 -> one cycle later: rd_edge_valid=1, rd_edge_addr=(0x35+i)>>4, active_v_id=0x35+i, value=1; the next cycle rd_edge_valid=0.
REQ-022 next_stage_full=1, write 13 vertices -> stage_full=1 after the 12th write; release -> 13 vertices emitted in order, one per cycle, stage_full returns to 0.
REQ-023 Write 17 vertices with next_stage_full=1 -> 16 stored, overflow_err=1; release -> exactly 16 emitted.
REQ-024 Vertex valid and end valid in the same cycle -> rd_edge_valid pulse, then iteration_end_valid=1 the next cycle, never together.
REQ-025 Reset asserted with 5 queued entries -> no further outputs, occupancy 0; a new write after release is emitted with 1-cycle latency.

Source files
------------

// File: rtl/rd_first_edge_addr_gen.sv
// Per-lane FIFO that turns active vertices into first-edge BRAM read addresses.
// State table:  EMIT     | pop the head entry and emit a vertex or end-only token
//               EMIT_END | vertex of a combined entry already sent, end token still owed
module rd_first_edge_addr_gen #(
    parameter int V_ID_WIDTH             = 32,
    parameter int V_VALUE_WIDTH          = 32,
    parameter int FIRST_EDGE_BRAM_AWIDTH = 11,
    parameter int CORE_NUM               = 16,
    parameter int CORE_NUM_WIDTH         = 4,
    parameter int FIFO_AWIDTH            = 4,
    parameter int FULL_THRESHOLD         = 12
) (
    input  logic                                         clk,
    input  logic [CORE_NUM-1:0]                          rst,
    input  logic [CORE_NUM-1:0]                          front_push_flag,
    input  logic [CORE_NUM*V_ID_WIDTH-1:0]               front_active_v_id,
    input  logic [CORE_NUM*V_VALUE_WIDTH-1:0]            front_active_v_value,
    input  logic [CORE_NUM-1:0]                          front_active_v_valid,
    input  logic [CORE_NUM-1:0]                          front_iteration_end,
    input  logic [CORE_NUM-1:0]                          front_iteration_end_valid,
    input  logic [CORE_NUM-1:0]                          next_stage_full,
    output logic [CORE_NUM-1:0]                          stage_full,
    output logic [CORE_NUM*FIRST_EDGE_BRAM_AWIDTH-1:0]   rd_edge_addr,
    output logic [CORE_NUM-1:0]                          push_flag,
    output logic [CORE_NUM*V_ID_WIDTH-1:0]               active_v_id,
    output logic [CORE_NUM*V_VALUE_WIDTH-1:0]            active_v_value,
    output logic [CORE_NUM-1:0]                          rd_edge_valid,
    output logic [CORE_NUM-1:0]                          iteration_end,
    output logic [CORE_NUM-1:0]                          iteration_end_valid,
    output logic [CORE_NUM-1:0]                          overflow_err
);

    localparam int DEPTH = 1 << FIFO_AWIDTH;

    typedef enum logic {EMIT = 1'b0, EMIT_END = 1'b1} state_t;

    typedef struct packed {
        logic                     push;
        logic [V_ID_WIDTH-1:0]    id;
        logic [V_VALUE_WIDTH-1:0] val;
        logic                     vf;
        logic                     ed;
        logic                     ef;
    } entry_t;

    for (genvar g = 0; g < CORE_NUM; g++) begin : g_lane
        entry_t                          r_mem [DEPTH];
        logic [FIFO_AWIDTH-1:0]          r_wr_ptr;
        logic [FIFO_AWIDTH-1:0]          r_rd_ptr;
        logic [FIFO_AWIDTH:0]            r_cnt;
        state_t                          r_state;
        logic                            r_stage_full;
        logic                            r_ovf;
        logic [FIRST_EDGE_BRAM_AWIDTH-1:0] r_addr;
        logic                            r_push;
        logic [V_ID_WIDTH-1:0]           r_id;
        logic [V_VALUE_WIDTH-1:0]        r_val;
        logic                            r_rd_valid;
        logic                            r_end;
        logic                            r_end_valid;

        entry_t                          w_head;
        entry_t                          w_wdata;
        logic [V_ID_WIDTH-1:0]           w_id_shift;
        logic [FIFO_AWIDTH:0]            w_cnt_nxt;
        logic                            w_wr_req;
        logic                            w_full;
        logic                            w_empty;
        logic                            w_emit;
        logic                            w_free;
        logic                            w_wr_en;

        assign w_wr_req = front_active_v_valid[g] | front_iteration_end_valid[g];

        assign w_wdata.push = front_push_flag[g];
        assign w_wdata.id   = front_active_v_id[g*V_ID_WIDTH +: V_ID_WIDTH];
        assign w_wdata.val  = front_active_v_value[g*V_VALUE_WIDTH +: V_VALUE_WIDTH];
        assign w_wdata.vf   = front_active_v_valid[g];
        assign w_wdata.ed   = front_iteration_end[g];
        assign w_wdata.ef   = front_iteration_end_valid[g];

        assign w_head     = r_mem[r_rd_ptr];
        assign w_id_shift = w_head.id >> CORE_NUM_WIDTH;

        // Occupancy can reach exactly DEPTH, so its MSB alone flags full.
        assign w_full  = r_cnt[FIFO_AWIDTH];
        assign w_empty = (r_cnt == '0);

        assign w_emit  = (r_state == EMIT) & ~w_empty & ~next_stage_full[g];
        // A combined vertex+end entry stays queued until its end token goes out.
        assign w_free  = (w_emit & ~(w_head.vf & w_head.ef))
                       | ((r_state == EMIT_END) & ~next_stage_full[g]);
        assign w_wr_en = w_wr_req & (~w_full | w_free);

        always_comb begin
            w_cnt_nxt = r_cnt;
            case ({w_wr_en, w_free})
                2'b10:   w_cnt_nxt = r_cnt + (FIFO_AWIDTH+1)'(1);
                2'b01:   w_cnt_nxt = r_cnt - (FIFO_AWIDTH+1)'(1);
                default: w_cnt_nxt = r_cnt;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst[g] && w_wr_en) begin
                r_mem[r_wr_ptr] <= w_wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst[g]) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_cnt        <= '0;
                r_state      <= EMIT;
                r_stage_full <= 1'b0;
                r_ovf        <= 1'b0;
                r_addr       <= '0;
                r_push       <= 1'b0;
                r_id         <= '0;
                r_val        <= '0;
                r_rd_valid   <= 1'b0;
                r_end        <= 1'b0;
                r_end_valid  <= 1'b0;
            end else begin
                if (w_wr_en) r_wr_ptr <= r_wr_ptr + FIFO_AWIDTH'(1);
                if (w_free)  r_rd_ptr <= r_rd_ptr + FIFO_AWIDTH'(1);
                r_cnt        <= w_cnt_nxt;
                r_stage_full <= (int'(w_cnt_nxt) >= FULL_THRESHOLD);
                if (w_wr_req && !w_wr_en) r_ovf <= 1'b1;

                r_rd_valid  <= 1'b0;
                r_end_valid <= 1'b0;
                case (r_state)
                    EMIT: begin
                        if (w_emit) begin
                            r_push <= w_head.push;
                            if (w_head.vf) begin
                                r_addr     <= w_id_shift[FIRST_EDGE_BRAM_AWIDTH-1:0];
                                r_id       <= w_head.id;
                                r_val      <= w_head.val;
                                r_rd_valid <= 1'b1;
                                if (w_head.ef) r_state <= EMIT_END;
                            end else begin
                                r_addr      <= '0;
                                r_end       <= w_head.ed;
                                r_end_valid <= 1'b1;
                            end
                        end
                    end
                    EMIT_END: begin
                        if (!next_stage_full[g]) begin
                            r_end       <= w_head.ed;
                            r_end_valid <= 1'b1;
                            r_state     <= EMIT;
                        end
                    end
                    default: r_state <= EMIT;
                endcase
            end
        end

        assign stage_full[g]                                              = r_stage_full;
        assign overflow_err[g]                                            = r_ovf;
        assign rd_edge_addr[g*FIRST_EDGE_BRAM_AWIDTH +: FIRST_EDGE_BRAM_AWIDTH] = r_addr;
        assign push_flag[g]                                               = r_push;
        assign active_v_id[g*V_ID_WIDTH +: V_ID_WIDTH]                    = r_id;
        assign active_v_value[g*V_VALUE_WIDTH +: V_VALUE_WIDTH]           = r_val;
        assign rd_edge_valid[g]                                           = r_rd_valid;
        assign iteration_end[g]                                           = r_end;
        assign iteration_end_valid[g]                                     = r_end_valid;
    end

endmodule
